// File: rtl/sar_search_ctrl.sv
// Successive-approximation search controller: walks a trial value MSB-first
// against an external magnitude comparator, with a final verify compare.
module sar_search_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [WIDTH-1:0] trial,
  output logic             trial_valid,
  input  logic             cmp_valid,
  input  logic             equal,
  input  logic             less_than,
  input  logic             greater_than,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic             error,
  output logic [WIDTH-1:0] result
);
  localparam int               IW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0]    IDX_TOP = IW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  typedef enum logic [1:0] {IDLE, PROBE, VERIFY, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [IW-1:0]    idx;

  logic             hs, onehot, last_bit;
  logic [WIDTH-1:0] acc_nxt, trial_nxt;

  always_comb begin
    hs        = trial_valid & cmp_valid;
    // odd flag count, excluding all three set, is exactly one
    onehot    = (equal ^ less_than ^ greater_than) & ~(equal & less_than & greater_than);
    last_bit  = (idx == '0);
    acc_nxt   = greater_than ? trial : acc;
    trial_nxt = last_bit ? acc_nxt : (acc_nxt | (ONE << (idx - IW'(1))));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      acc         <= '0;
      idx         <= IDX_TOP;
      trial       <= '0;
      trial_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      found       <= 1'b0;
      error       <= 1'b0;
      result      <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state       <= PROBE;
            acc         <= '0;
            idx         <= IDX_TOP;
            trial       <= ONE << IDX_TOP;
            trial_valid <= 1'b1;
            busy        <= 1'b1;
            done        <= 1'b0;
            found       <= 1'b0;
            error       <= 1'b0;
            result      <= '0;
          end
        end
        PROBE: begin
          if (hs) begin
            if (!onehot || equal) begin
              state       <= DONE;
              trial_valid <= 1'b0;
              busy        <= 1'b0;
              done        <= 1'b1;
              error       <= ~onehot;
              found       <= onehot;
              result      <= onehot ? trial : '0;
            end else begin
              acc   <= acc_nxt;
              trial <= trial_nxt;
              if (last_bit) state <= VERIFY;
              else          idx   <= idx - IW'(1);
            end
          end
        end
        VERIFY: begin
          // a one-hot lt/gt here means the comparator was inconsistent, not faulty
          if (hs) begin
            state       <= DONE;
            trial_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b1;
            error       <= ~onehot;
            found       <= onehot & equal;
            result      <= onehot ? acc : '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/sar_search_ctrl.md
Name: sar_search_ctrl

Overview:
- Successive-approximation search controller that drives the B side of a magnitude comparator and consumes its equal/less_than/greater_than flags.
- It recovers an unknown value A, held on the comparator's other input, in at most WIDTH+1 comparisons.
- It sits upstream of the comparator as its initiator, with a valid/valid handshake so a registered or pipelined comparator can be used.

Parameters:
WIDTH, 4, bit width of the trial value, the result and the comparator operands.

Ports:
clk  input  1  system clock; one clock, all state updates on its rising edge
rst_n  input  1  reset, synchronous, active-low
start  input  1  request a new search; honoured only in IDLE or DONE
trial  output  WIDTH  value driven to the comparator B operand
trial_valid  output  1  trial is stable and a comparison is requested
cmp_valid  input  1  flags below are valid for the current trial
equal  input  1  A == trial
less_than  input  1  A < trial
greater_than  input  1  A > trial
busy  output  1  search in progress
done  output  1  search finished; held until the next accepted start
found  output  1  qualified by done; the final verify compare returned equal
error  output  1  qualified by done; comparator flags were not one-hot
result  output  WIDTH  recovered value; qualified by done

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE. trial=0, trial_valid=0, busy=0, done=0, found=0, error=0, result=0. Internal acc=0, bit index idx=WIDTH-1. Reset overrides everything, including mid-search; the comparator sees trial_valid=0 on the next cycle.
- States: IDLE, PROBE, VERIFY, DONE.
- IDLE/DONE + start=1: go to PROBE. Set acc=0, idx=WIDTH-1, busy=1, done=0, found=0, error=0. result is held until then and cleared to 0 on this transition.
- PROBE:
  - trial = acc | (1<<idx), trial_valid=1. trial is held constant until the handshake.
  - The handshake occurs on a cycle with cmp_valid=1. Flags are sampled only on that cycle; flag values when cmp_valid=0 are ignored.
  - equal: result=trial, found=1, go to DONE (early exit).
  - greater_than: acc=trial (keep bit).
  - less_than: acc unchanged (drop bit).
  - After a keep/drop with idx>0: idx=idx-1, stay in PROBE. With idx==0: go to VERIFY.
- VERIFY: trial=acc, trial_valid=1. On handshake: result=acc; found=equal. If less_than or greater_than is asserted instead of equal, found=0 and error=0 (inconsistent but one-hot). Go to DONE.
- Flag check, on any handshake: if the number of asserted flags is not exactly one, set error=1, found=0, result=0, and go to DONE.
- DONE: busy=0, trial_valid=0, done=1; trial holds its last value. start returns to PROBE on the next edge (back-to-back searches allowed).
- start while busy: ignored, no restart.
- Latency with cmp_valid tied high:
  - start sampled at edge k; first trial_valid=1 in cycle k+1.
  - Each comparison takes 1 cycle.
  - done=1 from edge k+N, where N is the comparison count: 1..WIDTH+1, at most WIDTH+1.
- Extra cycles with cmp_valid low only stretch the current step; trial does not change.
- Arithmetic: all values are unsigned WIDTH bits. No carry is possible because bits are only OR-ed into acc.

Test Plan:
- WIDTH=4, A=8, cmp_valid=1, start pulse: one trial (8), equal; done at k+1; result=8, found=1, error=0.
- A=0: trials 8,4,2,1 all less_than, then VERIFY trial 0 equal; done at k+5; result=0, found=1.
- A=11: trials 8(gt), 12(lt), 10(gt), 11(eq); done at k+4; result=11, found=1. Repeat with cmp_valid low for 2 cycles per step: trial stable throughout, same result, done at k+12.
- A=15: trials 8,12,14 gt, then 15 eq; result=15, found=1. Assert start during the search: ignored.
- Inject equal=1 and greater_than=1 on the first handshake: done next edge, error=1, found=0, result=0.
- Drop rst_n during the third trial of A=11: after the reset edge, outputs are all 0 and state is IDLE. A fresh start then completes normally with result=11.
